// File: rtl/fft_bank_scheduler.sv
// Ping-pong bank scheduler for the FFT input sample buffer: tracks bank fill
// state, steers the writer, streams full banks to the FFT core and counts drops.
module fft_bank_scheduler #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_full,
  input  logic              fft_ready,
  input  logic              clr_overflow,
  output logic              sel_ram,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fft_start,
  output logic              rd_valid,
  output logic              fft_last,
  output logic              overflow,
  output logic [CNT_W-1:0]  frames_dropped
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_full;
  logic [1:0]          w_full_nxt;
  logic [1:0]          w_set_mask;
  logic [1:0]          w_clr_mask;
  logic                r_sel;
  logic                r_rd_bank;
  logic                w_rd_bank_nxt;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_fft_start;
  logic                r_rd_valid;
  logic                r_fft_last;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_dropped;
  logic                w_other_busy;
  logic                w_drop;
  logic                w_accept;
  logic                w_take;

  // A bank in DRAIN is already free, so only START/READ hold the reader's bank.
  assign w_other_busy = ((r_state == S_START) || (r_state == S_READ)) && (r_rd_bank == ~r_sel);
  assign w_drop       = wr_full && (r_full[~r_sel] || w_other_busy);
  assign w_accept     = wr_full && !w_drop;
  assign w_take       = (r_state == S_IDLE) && (r_full != 2'b00) && fft_ready;

  assign w_set_mask = w_accept ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr_mask = w_take ? (r_full[1] ? 2'b10 : 2'b01) : 2'b00;
  assign w_full_nxt = (r_full & ~w_clr_mask) | w_set_mask;

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt   = S_START;
          w_rd_bank_nxt = r_full[1];
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_START: w_state_nxt = S_READ;
      S_READ: begin
        if (r_rd_addr == LAST_ADDR) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_READ;
        end
      end
      S_DRAIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_full      <= 2'b00;
      r_sel       <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= {ADDR_W{1'b0}};
      r_fft_start <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_fft_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_full      <= w_full_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      if (w_accept) begin
        r_sel <= ~r_sel;
      end
      r_fft_start <= (w_state_nxt == S_START);
      r_rd_en     <= (w_state_nxt == S_READ);
      r_rd_addr   <= ((r_state == S_READ) && (w_state_nxt == S_READ)) ? (r_rd_addr + ADDR_ONE)
                                                                      : {ADDR_W{1'b0}};
      r_rd_valid  <= r_rd_en;
      r_fft_last  <= r_rd_en && (r_rd_addr == LAST_ADDR);
    end
  end

  // A drop in the same cycle as a clear wins, leaving a count of one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_dropped  <= {CNT_W{1'b0}};
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_overflow) begin
        r_dropped <= CNT_ONE;
      end else if (r_dropped != CNT_MAX) begin
        r_dropped <= r_dropped + CNT_ONE;
      end
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
      r_dropped  <= {CNT_W{1'b0}};
    end
  end

  assign sel_ram        = r_sel;
  assign rd_bank        = r_rd_bank;
  assign rd_en          = r_rd_en;
  assign rd_addr        = r_rd_addr;
  assign fft_start      = r_fft_start;
  assign rd_valid       = r_rd_valid;
  assign fft_last       = r_fft_last;
  assign overflow       = r_overflow;
  assign frames_dropped = r_dropped;

endmodule

// File: tb/tb_fft_bank_scheduler.sv
// Bench for fft_bank_scheduler (N = 8): frame-position model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fft_bank_scheduler;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;
  localparam int N      = 8;

  logic              clock;
  logic              reset;
  logic              wr_full;
  logic              fft_ready;
  logic              clr_overflow;
  logic              sel_ram;
  logic              rd_bank;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              fft_start;
  logic              rd_valid;
  logic              fft_last;
  logic              overflow;
  logic [CNT_W-1:0]  frames_dropped;

  fft_bank_scheduler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .wr_full(wr_full), .fft_ready(fft_ready),
    .clr_overflow(clr_overflow), .sel_ram(sel_ram), .rd_bank(rd_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .fft_start(fft_start),
    .rd_valid(rd_valid), .fft_last(fft_last), .overflow(overflow),
    .frames_dropped(frames_dropped)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: frame position -1 = idle, 0 = start, 1..N = reading sample pos-1, N+1 = drain.
  int         m_pos;
  logic [1:0] m_full;
  logic [1:0] m_full_n;
  logic       m_sel;
  logic       m_rdb;
  int         m_cnt;
  logic       m_ovf;
  logic       m_busy_o;
  logic       m_take;

  always_comb begin
    m_busy_o = m_full[!m_sel] || (m_pos >= 0 && m_pos <= N && m_rdb == !m_sel);
    m_take   = (m_pos == -1) && (m_full != 2'b00) && fft_ready;
    m_full_n = m_full;
    if (m_take) m_full_n[m_full[1]] = 1'b0;
    if (wr_full && !m_busy_o) m_full_n[m_sel] = 1'b1;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pos <= -1; m_full <= 2'b00; m_sel <= 1'b0; m_rdb <= 1'b0;
      m_cnt <= 0;  m_ovf <= 1'b0;
    end else begin
      m_full <= m_full_n;
      if (m_take) begin
        m_rdb <= m_full[1];
        m_pos <= 0;
      end else if (m_pos == N + 1) m_pos <= -1;
      else if (m_pos >= 0) m_pos <= m_pos + 1;
      if (wr_full && !m_busy_o) m_sel <= !m_sel;
      if (wr_full && m_busy_o) begin
        m_ovf <= 1'b1;
        m_cnt <= clr_overflow ? 1 : m_cnt + 1;
      end else if (clr_overflow) begin
        m_ovf <= 1'b0;
        m_cnt <= 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (!reset && chk_on) begin
      check("sel_ram", sel_ram, m_sel);
      check("rd_bank", rd_bank, m_rdb);
      check("fft_start", fft_start, m_pos == 0);
      check("rd_en", rd_en, m_pos >= 1 && m_pos <= N);
      check("rd_valid", rd_valid, m_pos >= 2 && m_pos <= N + 1);
      check("fft_last", fft_last, m_pos == N + 1);
      check("overflow", overflow, m_ovf);
      check("frames_dropped", frames_dropped, (m_cnt > 255) ? 255 : m_cnt);
      if (m_pos >= 0 && m_pos <= N) check("rd_addr", rd_addr, (m_pos == 0) ? 0 : m_pos - 1);
    end
  end

  // Event monitor used by the directed checks.
  int   cyc = 0, n_starts = 0, n_lasts = 0, n_rden = 0, start_cyc = 0, last_cyc = 0;
  logic bank_q[$];
  int   addr_q[$];
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (fft_start) begin
      n_starts  <= n_starts + 1;
      start_cyc <= cyc;
      bank_q.push_back(rd_bank);
    end
    if (fft_last) begin
      n_lasts  <= n_lasts + 1;
      last_cyc <= cyc;
    end
    if (rd_en) begin
      n_rden <= n_rden + 1;
      addr_q.push_back(int'(rd_addr));
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse_wr();
    wr_full = 1'b1;
    tick();
    wr_full = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_addr(input int a);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (rd_en && int'(rd_addr) == a) found = 1'b1;
      else tick();
    end
    check("wait_addr_timeout", found, 1);
  endtask

  task automatic wait_last();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (fft_last) found = 1'b1;
      else tick();
    end
    check("wait_last_timeout", found, 1);
  endtask

  int s0, l0, r0;

  initial begin
    reset = 1'b1; wr_full = 1'b0; fft_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(posedge clock);
    tick();
    reset  = 1'b0;
    chk_on = 1'b1;
    tick();
    check("rst_sel_ram", sel_ram, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_fft_last", fft_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frames_dropped", frames_dropped, 0);

    // Fill bank 0 with the core not ready: writer moves to bank 1, no frame.
    pulse_wr();
    check("fill_sel_ram", sel_ram, 1);
    repeat (3) tick();
    check("fill_no_start", n_starts, 0);

    // Single frame once the core is ready.
    s0 = n_starts; r0 = n_rden; addr_q.delete(); bank_q.delete();
    fft_ready = 1'b1;
    repeat (14) tick();
    check("single_starts", n_starts - s0, 1);
    check("single_lasts", n_lasts, 1);
    check("single_rden_cycles", n_rden - r0, 8);
    check("single_start_to_last", last_cyc - start_cyc, 9);
    check("single_bank", (bank_q.size() > 0) ? bank_q[0] : 1'bx, 0);
    for (int i = 0; i < 8; i++)
      check("single_addr_seq", (addr_q.size() > i) ? addr_q[i] : -1, i);

    // Ping-pong: one completed bank every 12 cycles.
    do_reset();
    fft_ready = 1'b1;
    bank_q.delete();
    for (int i = 0; i < 4; i++) begin
      pulse_wr();
      repeat (11) tick();
    end
    check("pp_frames", bank_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("pp_bank", (bank_q.size() > i) ? bank_q[i] : 1'bx, i % 2);
    check("pp_overflow", overflow, 0);

    // Drop while bank 0 is being read; a completion in DRAIN succeeds.
    do_reset();
    fft_ready = 1'b1;
    pulse_wr();
    wait_addr(2);
    pulse_wr();
    check("drop_sel_ram", sel_ram, 1);
    check("drop_overflow", overflow, 1);
    check("drop_count", frames_dropped, 1);
    wait_last();
    pulse_wr();
    check("drain_sel_ram", sel_ram, 0);
    check("drain_count", frames_dropped, 1);
    s0 = n_starts;
    for (int i = 0; i < 5 && n_starts == s0; i++) tick();
    check("drain_next_start", n_starts - s0, 1);
    check("drain_next_bank", rd_bank, 1);

    // Saturation and clear.
    do_reset();
    fft_ready = 1'b0;
    pulse_wr();
    wr_full = 1'b1;
    repeat (300) tick();
    wr_full = 1'b0;
    tick();
    check("sat_count", frames_dropped, 255);
    check("sat_overflow", overflow, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_count", frames_dropped, 0);
    check("clr_overflow", overflow, 0);
    clr_overflow = 1'b1;
    wr_full = 1'b1;
    tick();
    clr_overflow = 1'b0;
    wr_full = 1'b0;
    check("clr_drop_count", frames_dropped, 1);
    check("clr_drop_overflow", overflow, 1);

    // Reset mid-frame: bank 0 is still full, so raising ready starts a frame.
    fft_ready = 1'b1;
    wait_addr(4);
    l0 = n_lasts;
    reset = 1'b1;
    #1;
    check("mid_rd_en", rd_en, 0);
    check("mid_rd_addr", rd_addr, 0);
    check("mid_sel_ram", sel_ram, 0);
    check("mid_rd_valid", rd_valid, 0);
    check("mid_overflow", overflow, 0);
    tick();
    tick();
    reset = 1'b0;
    s0 = n_starts;
    repeat (15) tick();
    check("mid_no_last", n_lasts - l0, 0);
    check("mid_no_restart", n_starts - s0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
